// File: rtl/tel_receiver.sv
// Callee-side phone endpoint: rings on an incoming call, lets the user answer or decline,
// and captures the caller's character stream into an 8-character display buffer.
module tel_receiver #(
  parameter int RING_TIMEOUT   = 10,
  parameter int HOLD_CYCLES    = 10,
  parameter int SUMMARY_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        incomingCall,
  input  logic        callerHangup,
  input  logic        answerCall,
  input  logic        rejectCall,
  input  logic        endCall,
  input  logic        charValid,
  input  logic [7:0]  charIn,
  output logic [63:0] statusMsg,
  output logic [63:0] recvMsg,
  output logic [7:0]  recvCount,
  output logic        accepted,
  output logic        rejected,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, RINGING, MISSED, DECLINED, CONNECTED, SUMMARY
  } state_t;

  localparam logic [7:0]  RING_LAST    = 8'(RING_TIMEOUT - 1);
  localparam logic [7:0]  HOLD_LAST    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]  SUMMARY_LAST = 8'(SUMMARY_CYCLES - 1);
  localparam logic [63:0] BLANK        = {8{8'h20}};
  localparam logic [7:0]  DEL          = 8'd127;

  state_t      state, next_state;
  logic [7:0]  counter;
  logic        accept_nxt, reject_nxt;
  logic [63:0] status_nxt;
  logic        printable;

  assign printable = charValid && (charIn >= 8'd32) && (charIn <= 8'd126);

  always_comb begin
    next_state = state;
    accept_nxt = 1'b0;
    reject_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (incomingCall) next_state = RINGING;
      end
      // Caller hangup outranks the local user; decline outranks answer.
      RINGING: begin
        if (callerHangup) begin
          next_state = MISSED;
        end else if (rejectCall) begin
          next_state = DECLINED;
          reject_nxt = 1'b1;
        end else if (answerCall) begin
          next_state = CONNECTED;
          accept_nxt = 1'b1;
        end else if (counter == RING_LAST) begin
          next_state = MISSED;
        end
      end
      MISSED, DECLINED: begin
        if (counter == HOLD_LAST) next_state = IDLE;
      end
      CONNECTED: begin
        if (endCall || callerHangup || (charValid && charIn == DEL)) next_state = SUMMARY;
      end
      SUMMARY: begin
        if (counter == SUMMARY_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    status_nxt = "IDLE    ";
    case (next_state)
      RINGING:   status_nxt = "INCOMING";
      MISSED:    status_nxt = "MISSED  ";
      DECLINED:  status_nxt = "DECLINED";
      CONNECTED: status_nxt = "ON CALL ";
      SUMMARY:   status_nxt = "RECEIVED";
      default:   status_nxt = "IDLE    ";
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= 8'd0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        counter <= 8'd0;
      end else if (state == RINGING || state == MISSED ||
                   state == DECLINED || state == SUMMARY) begin
        counter <= counter + 8'd1;
      end
    end
  end

  // Outputs are registered from next_state so they move on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statusMsg <= "IDLE    ";
      recvMsg   <= BLANK;
      recvCount <= 8'd0;
      accepted  <= 1'b0;
      rejected  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      statusMsg <= status_nxt;
      accepted  <= accept_nxt;
      rejected  <= reject_nxt;
      busy      <= (next_state != IDLE);
      if (state == IDLE && incomingCall) begin
        recvMsg   <= BLANK;
        recvCount <= 8'd0;
      end else if (state == CONNECTED && printable) begin
        recvMsg <= {recvMsg[55:0], charIn};
        if (recvCount != 8'hFF) recvCount <= recvCount + 8'd1;
      end
    end
  end

endmodule
